snes_joypad: RTL and testbench
==============================

Name: snes_joypad

Overview:
- Controller-side responder for the SCPU serial joypad port: the SCPU drives strobe and clock, and this block returns data.
- Latches a 12-button state on JOY_STRB, then shifts one bit per JOY_CLK rising edge onto JOY_DI.
- Line levels are hardware-accurate and active-low.
- One instance per port (pad 1 / pad 2) beside the SNES top level, fed by the board's button source.

Parameters:
- ID_BITS, 4'b0000: controller signature returned in serial bits 12..15; 0000 = standard pad.
- TURBO_DIV, 4: strobes per turbo half-period (used only with JOYPAD_TURBO_EN).

Ports:
- WCLK  in  1  system clock, same domain as the SCPU joypad outputs
- RST_N  in  1  reset, asynchronous active-low
- ENABLE  in  1  when 0, all state frozen and edges ignored
- JOY_STRB  in  1  latch strobe from SCPU, active-high level
- JOY_CLK  in  1  serial clock from SCPU, idles high
- BTN  in  12  button state, 1 = pressed. Order is [0]=B [1]=Y [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right [8]=A [9]=X [10]=L [11]=R. Asynchronous to WCLK.
- JOY_DI  out  2  [0] serial data, 0 = pressed/asserted; [1] constant 1 (no multitap)
- BIT_CNT  out  5  bits shifted since last latch, saturates at 16
- LATCH_PULSE  out  1  one-WCLK pulse on each strobe falling edge

Behaviour:
- Reset (async, RST_N=0):
  - shift register = 16'hFFFF, JOY_DI = 2'b11, BIT_CNT = 0, LATCH_PULSE = 0, state = IDLE.
  - Edge-detect registers reset to strb=0, clk=1.
- BTN synchronization: 2-flop synchronizer per bit, giving 2 WCLK latency to sampling.
- Edge detection: registered copies of JOY_STRB and JOY_CLK, updated only when ENABLE=1.
  - Rise = cur & ~prev; fall = ~cur & prev.
- Shift register sr[15:0], active-low image:
  - sr[11:0] = ~BTN_sync
  - sr[15:12] = ~ID_BITS
  - JOY_DI[0] = sr[0], registered.
- State machine:
  - IDLE: JOY_DI[0]=1 until first strobe. On strobe rise -> LOAD.
  - LOAD (strobe high): reload sr every WCLK, so JOY_DI[0] tracks ~B live. BIT_CNT = 0. JOY_CLK edges are ignored. On strobe fall -> SHIFT, with a final reload on that cycle and LATCH_PULSE=1.
  - SHIFT: on each JOY_CLK rise, sr <= {1'b0, sr[15:1]} and BIT_CNT++. On BIT_CNT reaching 16 -> DONE. Strobe rise -> LOAD (aborts a partial read).
  - DONE: JOY_DI[0]=0 (reads as 1 past bit 16). Further clock rises are ignored and BIT_CNT stays 16. Strobe rise -> LOAD.
- Output timing: JOY_DI[0] changes the WCLK after the detected JOY_CLK rise. It is stable for the whole following low phase, which the SCPU samples.
- Simultaneous events: strobe rise and clock rise in the same cycle -> strobe wins (LOAD), no shift.
- BTN changes after the strobe fall do not affect the current read.
- ENABLE=0 mid-read: sr, BIT_CNT, state and edge registers hold. No edges are recognized while disabled. On re-enable, edge registers compare against the held values.
- Reset mid-read: immediate return to reset values regardless of strobe/clock levels.

Optional Feature:
- Macro: JOYPAD_TURBO_EN.
- Defined:
  - Extra input TURBO[3:0], mapping [0]=B [1]=Y [2]=A [3]=X.
  - A 4-bit strobe counter counts LATCH_PULSEs and wraps at TURBO_DIV-1. On wrap, a phase bit toggles; phase resets to 0.
  - Effective press = BTN & ~(TURBO & phase). With TURBO_DIV=4, a held turbo button reads pressed 4 latches, released 4 latches.
- Undefined: no TURBO port, no counter; sr loads directly from BTN_sync.

Test Plan:
1. Reset with JOY_STRB=0 -> JOY_DI=2'b11, BIT_CNT=0, LATCH_PULSE=0.
2. BTN=12'h001 (B), strobe high 12 cycles then low, 16 clock pulses:
   - While the strobe is high, JOY_DI[0]=0.
   - After the fall, JOY_DI[0] serial = 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1.
   - BIT_CNT=16.
3. BTN=12'hA50, ID_BITS=4'b0000:
   - Bits 0..11 read LSB-first as ~12'hA50 (pressed bits 4,6,9,11 at 0).
   - Bits 12..15 = 1.
   - 17th and 18th clocks -> JOY_DI[0]=0, BIT_CNT stays 16.
4. Read aborted after 5 clocks by a new strobe with BTN changed to 12'h100 -> BIT_CNT=0, first bit =1, bit 8 (A) =0.
5. Strobe rise coincident with clock rise -> no shift, BIT_CNT=0. ENABLE=0 during 3 clock pulses -> BIT_CNT and JOY_DI unchanged.
6. JOYPAD_TURBO_EN, TURBO=4'b0001, BTN[0]=1, TURBO_DIV=4, 8 latches -> B bit reads 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/snes_joypad.sv
// ----------------------------------------------------------------------------
// snes_joypad -- controller-side responder for the SCPU serial joypad port.
//
// The SCPU drives JOY_STRB (latch) and JOY_CLK (shift clock); this block
// latches the 12 buttons plus a 4-bit signature into an active-low shift
// register and returns one bit per JOY_CLK rising edge on JOY_DI[0].
//
// Ports:
//   WCLK        in   system clock (same domain as SCPU joypad outputs)
//   RST_N       in   asynchronous active-low reset
//   ENABLE      in   0 freezes all read state and ignores edges
//   JOY_STRB    in   latch strobe, active-high level
//   JOY_CLK     in   serial clock, idles high
//   BTN[11:0]   in   buttons, 1 = pressed (B,Y,Sel,Start,U,D,L,R,A,X,L,R)
//   TURBO[3:0]  in   turbo enables for B,Y,A,X (JOYPAD_TURBO_EN only)
//   JOY_DI[1:0] out  [0] serial data, 0 = pressed; [1] constant 1
//   BIT_CNT     out  bits shifted since last latch, saturates at 16
//   LATCH_PULSE out  one-WCLK pulse per strobe falling edge
//
// Build option: define JOYPAD_TURBO_EN to add the TURBO input and the
// strobe-counted turbo phase (parameter TURBO_DIV exists only then).
// ----------------------------------------------------------------------------
module snes_joypad #(
  parameter logic [3:0] ID_BITS = 4'b0000
`ifdef JOYPAD_TURBO_EN
  , parameter int TURBO_DIV = 4
`endif
) (
  input  logic        WCLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        JOY_STRB,
  input  logic        JOY_CLK,
  input  logic [11:0] BTN,
`ifdef JOYPAD_TURBO_EN
  input  logic [3:0]  TURBO,
`endif
  output logic [1:0]  JOY_DI,
  output logic [4:0]  BIT_CNT,
  output logic        LATCH_PULSE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] btn_meta_q, btn_sync_q;
  logic        strb_prev_q, clk_prev_q;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        di_q, di_d;
  logic        latch_q, latch_d;
  logic        strb_rise_s, strb_fall_s, clk_rise_s;
  logic [11:0] btn_eff_s;
  logic [15:0] load_img_s;

  // Edges only exist while enabled; the previous-level registers hold otherwise.
  assign strb_rise_s = ENABLE &  JOY_STRB & ~strb_prev_q;
  assign strb_fall_s = ENABLE & ~JOY_STRB &  strb_prev_q;
  assign clk_rise_s  = ENABLE &  JOY_CLK  & ~clk_prev_q;

`ifdef JOYPAD_TURBO_EN
  logic [3:0] turbo_cnt_q;
  logic       phase_q;

  // Strobe counter: advances per latch, toggles the turbo phase on wrap.
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      turbo_cnt_q <= 4'd0;
      phase_q     <= 1'b0;
    end else if (strb_fall_s) begin
      if (turbo_cnt_q == 4'(TURBO_DIV - 1)) begin
        turbo_cnt_q <= 4'd0;
        phase_q     <= ~phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + 4'd1;
      end
    end
  end

  // Turbo bits B,Y,A,X sit at button positions 0,1,8,9.
  assign btn_eff_s = btn_sync_q &
                     ~({2'b00, TURBO[3:2], 6'b000000, TURBO[1:0]} & {12{phase_q}});
`else
  assign btn_eff_s = btn_sync_q;
`endif

  assign load_img_s = {~ID_BITS, ~btn_eff_s};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta_q <= 12'h000;
      btn_sync_q <= 12'h000;
    end else begin
      btn_meta_q <= BTN;
      btn_sync_q <= btn_meta_q;
    end
  end

  // State register plus edge-detect history; frozen while disabled.
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      strb_prev_q <= 1'b0;
      clk_prev_q  <= 1'b1;
    end else if (ENABLE) begin
      state_q     <= state_d;
      strb_prev_q <= JOY_STRB;
      clk_prev_q  <= JOY_CLK;
    end
  end

  // Next-state logic; a strobe rise always wins over a coincident clock rise.
  always_comb begin
    state_d = state_q;
    if (strb_rise_s) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_LOAD:  state_d = strb_fall_s ? S_SHIFT : S_LOAD;
        S_SHIFT: state_d = (clk_rise_s && (cnt_q == 5'd15)) ? S_DONE : S_SHIFT;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath/output next values: reload while latching (including the final
  // cycle of the strobe fall), shift on clock rises, pin the line otherwise.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    latch_d = strb_fall_s;
    if ((state_d == S_LOAD) || (state_q == S_LOAD)) begin
      sr_d  = load_img_s;
      cnt_d = 5'd0;
    end else if ((state_q == S_SHIFT) && clk_rise_s) begin
      sr_d  = {1'b0, sr_q[15:1]};
      cnt_d = cnt_q + 5'd1;
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
    case (state_d)
      S_IDLE:  di_d = 1'b1;
      S_DONE:  di_d = 1'b0;
      default: di_d = sr_d[0];
    endcase
  end

  // Datapath and registered outputs; only the latch pulse clears when disabled.
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q    <= 16'hFFFF;
      cnt_q   <= 5'd0;
      di_q    <= 1'b1;
      latch_q <= 1'b0;
    end else if (ENABLE) begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      di_q    <= di_d;
      latch_q <= latch_d;
    end else begin
      latch_q <= 1'b0;
    end
  end

  assign JOY_DI      = {1'b1, di_q};
  assign BIT_CNT     = cnt_q;
  assign LATCH_PULSE = latch_q;

endmodule

// File: tb/tb_snes_joypad.sv
// Self-checking bench for snes_joypad. The reference model treats a read as
// the 16-bit word {ID, buttons} returned LSB first with inverted polarity,
// followed by zeros, and turbo as a press masked every other group of
// TURBO_DIV latches.
module tb_snes_joypad;

  localparam logic [3:0] TB_ID = 4'b0000;
  localparam int TB_TDIV = 4;

  logic        WCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b1;
  logic        JOY_STRB = 1'b0;
  logic        JOY_CLK = 1'b1;
  logic [11:0] BTN = 12'h000;
  logic [1:0]  JOY_DI;
  logic [4:0]  BIT_CNT;
  logic        LATCH_PULSE;
`ifdef JOYPAD_TURBO_EN
  logic [3:0]  TURBO = 4'b0000;
`endif

  int checks = 0;
  int failures = 0;

  snes_joypad #(
    .ID_BITS(TB_ID)
`ifdef JOYPAD_TURBO_EN
    , .TURBO_DIV(TB_TDIV)
`endif
  ) dut (
    .WCLK(WCLK),
    .RST_N(RST_N),
    .ENABLE(ENABLE),
    .JOY_STRB(JOY_STRB),
    .JOY_CLK(JOY_CLK),
    .BTN(BTN),
`ifdef JOYPAD_TURBO_EN
    .TURBO(TURBO),
`endif
    .JOY_DI(JOY_DI),
    .BIT_CNT(BIT_CNT),
    .LATCH_PULSE(LATCH_PULSE)
  );

  always #5 WCLK = ~WCLK;

  // Reference: bit k seen by the SCPU after latching buttons btn.
  function automatic logic model_bit(input logic [11:0] btn, input int k);
    logic [15:0] word;
    word = {TB_ID, btn};
    if (k < 16) return ~word[k];
    return 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge WCLK);
    #1;
  endtask

  // Latch btn: strobe high for hold cycles, then low; reports the pulse level
  // on the cycle after the fall and on the cycle after that.
  task automatic strobe_latch(input logic [11:0] btn, input int hold,
                              output logic p1, output logic p2);
    BTN = btn;
    tick(3);
    JOY_STRB = 1'b1;
    tick(hold);
    JOY_STRB = 1'b0;
    tick(1);
    p1 = LATCH_PULSE;
    tick(1);
    p2 = LATCH_PULSE;
  endtask

  // Clock n pulses, sampling JOY_DI[0] in each low phase.
  task automatic read_bits(input int n, output logic [19:0] bits);
    bits = 20'h00000;
    for (int k = 0; k < n; k++) begin
      JOY_CLK = 1'b0;
      tick(2);
      bits[k] = JOY_DI[0];
      JOY_CLK = 1'b1;
      tick(2);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    JOY_STRB = 1'b0;
    JOY_CLK = 1'b1;
    ENABLE = 1'b1;
    tick(2);
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(2);
    checks++;
    if (JOY_DI !== 2'b11 || BIT_CNT !== 5'd0 || LATCH_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL reset: di=%b cnt=%0d pulse=%b, want di=11 cnt=0 pulse=0",
               JOY_DI, BIT_CNT, LATCH_PULSE);
    end
    RST_N = 1'b1;
    tick(3);
    checks++;
    if (JOY_DI !== 2'b11) begin
      failures++;
      $display("FAIL idle_di: di=%b want 11", JOY_DI);
    end
  endtask

  task automatic test_single_b();
    logic [19:0] bits;
    BTN = 12'h001;
    tick(3);
    JOY_STRB = 1'b1;
    tick(6);
    checks++;
    if (JOY_DI[0] !== 1'b0 || BIT_CNT !== 5'd0) begin
      failures++;
      $display("FAIL strobe_live_b: di0=%b cnt=%0d want 0 0", JOY_DI[0], BIT_CNT);
    end
    tick(6);
    JOY_STRB = 1'b0;
    tick(1);
    checks++;
    if (LATCH_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL latch_pulse_hi: got %b want 1", LATCH_PULSE);
    end
    tick(1);
    checks++;
    if (LATCH_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL latch_pulse_lo: got %b want 0", LATCH_PULSE);
    end
    read_bits(16, bits);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bits[k] !== model_bit(12'h001, k)) begin
        failures++;
        $display("FAIL b_serial bit%0d: got %b want %b", k, bits[k], model_bit(12'h001, k));
      end
    end
    checks++;
    if (BIT_CNT !== 5'd16) begin
      failures++;
      $display("FAIL b_cnt: got %0d want 16", BIT_CNT);
    end
  endtask

  task automatic test_pattern_a50();
    logic [19:0] bits;
    logic p1, p2;
    strobe_latch(12'hA50, 12, p1, p2);
    read_bits(16, bits);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bits[k] !== model_bit(12'hA50, k)) begin
        failures++;
        $display("FAIL a50_serial bit%0d: got %b want %b", k, bits[k], model_bit(12'hA50, k));
      end
    end
    checks++;
    if (BIT_CNT !== 5'd16) begin
      failures++;
      $display("FAIL a50_cnt16: got %0d want 16", BIT_CNT);
    end
    read_bits(2, bits);
    checks++;
    if (bits[1:0] !== 2'b00 || BIT_CNT !== 5'd16 || JOY_DI[0] !== 1'b0) begin
      failures++;
      $display("FAIL a50_overrun: bits=%b cnt=%0d di0=%b want 00 16 0",
               bits[1:0], BIT_CNT, JOY_DI[0]);
    end
  endtask

  task automatic test_abort();
    logic [19:0] bits;
    logic p1, p2;
    strobe_latch(12'hA50, 8, p1, p2);
    read_bits(5, bits);
    checks++;
    if (BIT_CNT !== 5'd5) begin
      failures++;
      $display("FAIL abort_partial_cnt: got %0d want 5", BIT_CNT);
    end
    strobe_latch(12'h100, 8, p1, p2);
    checks++;
    if (BIT_CNT !== 5'd0 || p1 !== 1'b1) begin
      failures++;
      $display("FAIL abort_relatch: cnt=%0d pulse=%b want 0 1", BIT_CNT, p1);
    end
    read_bits(16, bits);
    checks++;
    if (bits[0] !== 1'b1 || bits[8] !== 1'b0) begin
      failures++;
      $display("FAIL abort_bits: b0=%b b8=%b want 1 0", bits[0], bits[8]);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bits[k] !== model_bit(12'h100, k)) begin
        failures++;
        $display("FAIL abort_serial bit%0d: got %b want %b", k, bits[k], model_bit(12'h100, k));
      end
    end
  endtask

  task automatic test_coincident_and_enable();
    logic [19:0] bits;
    logic p1, p2;
    logic held_di;
    strobe_latch(12'h0F0, 8, p1, p2);
    read_bits(3, bits);
    JOY_CLK = 1'b0;
    tick(2);
    JOY_STRB = 1'b1;
    JOY_CLK = 1'b1;
    tick(2);
    checks++;
    if (BIT_CNT !== 5'd0 || JOY_DI[0] !== model_bit(12'h0F0, 0)) begin
      failures++;
      $display("FAIL coincident: cnt=%0d di0=%b want 0 %b", BIT_CNT, JOY_DI[0],
               model_bit(12'h0F0, 0));
    end
    JOY_STRB = 1'b0;
    tick(2);
    read_bits(2, bits);
    held_di = model_bit(12'h0F0, 2);
    ENABLE = 1'b0;
    tick(1);
    read_bits(3, bits);
    checks++;
    if (BIT_CNT !== 5'd2 || bits[2:0] !== {3{held_di}}) begin
      failures++;
      $display("FAIL disabled_hold: cnt=%0d bits=%b want 2 %b", BIT_CNT, bits[2:0],
               {3{held_di}});
    end
    ENABLE = 1'b1;
    tick(2);
    checks++;
    if (BIT_CNT !== 5'd2 || JOY_DI[0] !== held_di) begin
      failures++;
      $display("FAIL reenable: cnt=%0d di0=%b want 2 %b", BIT_CNT, JOY_DI[0], held_di);
    end
    read_bits(14, bits);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (bits[k] !== model_bit(12'h0F0, k + 2)) begin
        failures++;
        $display("FAIL resume_serial bit%0d: got %b want %b", k + 2, bits[k],
                 model_bit(12'h0F0, k + 2));
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] bits_a, bits_b, got, exp;
    logic [11:0] btn;
    logic p1, p2;
    for (int it = 0; it < 8; it++) begin
      btn = 12'($urandom);
      strobe_latch(btn, $urandom_range(2, 10), p1, p2);
      read_bits(8, bits_a);
      BTN = 12'($urandom);
      read_bits(10, bits_b);
      got = {2'b00, bits_b[9:0], bits_a[7:0]};
      exp = 20'h00000;
      for (int k = 0; k < 18; k++) exp[k] = model_bit(btn, k);
      checks++;
      if (got !== exp || BIT_CNT !== 5'd16 || p1 !== 1'b1 || p2 !== 1'b0) begin
        failures++;
        $display("FAIL random_read btn=%h: bits=%h cnt=%0d pulse=%b%b want %h 16 10",
                 btn, got, BIT_CNT, p1, p2, exp);
      end
    end
  endtask

  task automatic test_reset_midread();
    logic [19:0] bits;
    logic p1, p2;
    strobe_latch(12'h3C3, 6, p1, p2);
    read_bits(4, bits);
    JOY_CLK = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (JOY_DI !== 2'b11 || BIT_CNT !== 5'd0 || LATCH_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL reset_midread: di=%b cnt=%0d pulse=%b want 11 0 0",
               JOY_DI, BIT_CNT, LATCH_PULSE);
    end
    JOY_CLK = 1'b1;
    tick(2);
    RST_N = 1'b1;
    tick(2);
  endtask

`ifdef JOYPAD_TURBO_EN
  task automatic test_turbo();
    logic p1, p2;
    logic exp;
    do_reset();
    TURBO = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      strobe_latch(12'h001, 4, p1, p2);
      exp = ((i / TB_TDIV) % 2) == 1;
      checks++;
      if (JOY_DI[0] !== exp) begin
        failures++;
        $display("FAIL turbo latch%0d: di0=%b want %b", i, JOY_DI[0], exp);
      end
    end
    TURBO = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_single_b();
    test_pattern_a50();
    test_abort();
    test_coincident_and_enable();
    test_random();
    test_reset_midread();
`ifdef JOYPAD_TURBO_EN
    test_turbo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
